csr_timer_int: RTL and testbench
================================

# csr_timer_int

Parametrised timer and interrupt-pending unit for the LoongArch CSR file. It owns TID, TCFG, TVAL and TICLR, counts the constant timer, and latches the timer interrupt (TI). It synchronises the external hardware and IPI interrupt lines and combines them with the software bits and ECFG.LIE into the core interrupt request. The main CSR block forwards CSR accesses here, muxes `rdata` back when `hit` is set, and reads `is_bits` into ESTAT.IS.

## Interface
- `TIMER_W`, default 32: timer width, legal range 8..32. TCFG.InitVal is `TIMER_W-2` bits.
- `HW_INT_N`, default 8: number of hardware interrupt lines, 1..8. Unused IS[9:2] bits read 0.
- `SYNC_STAGES`, default 2: synchroniser depth for `hw_int` and `ipi_int`, minimum 2.
- `CORE_ID`, default 32'h0: TID reset value.

Ports:
- `clk` in 1: the single clock; everything is on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `csr_num` in 14: CSR address. TID=0x40, TCFG=0x41, TVAL=0x42, TICLR=0x44.
- `we` in 1: CSR write strobe, single cycle.
- `wdata` in 32: write data.
- `wmask` in 32: per-bit write mask.
- `rdata` out 32: read data, combinational from `csr_num`.
- `hit` out 1: `csr_num` is one of the four addresses above.
- `hw_int` in HW_INT_N: asynchronous level hardware interrupts.
- `ipi_int` in 1: asynchronous level inter-processor interrupt.
- `sw_int` in 2: ESTAT.IS[1:0] from the main CSR block.
- `ecfg_lie` in 13: ECFG.LIE.
- `crmd_ie` in 1: CRMD.IE.
- `is_bits` out 13: `{ipi_s, ti, 1'b0, hw_s padded to 8, sw_int}`.
- `int_signal` out 1: `crmd_ie & |(ecfg_lie & is_bits)`.

## Operation
- Masked write rule for every writable field: `new = wmask & wdata | ~wmask & old`.
- TID: 32-bit read/write register.
- TCFG: En = bit 0, Periodic = bit 1, InitVal = bits `[TIMER_W-1:2]`. Read is zero-extended.
- TVAL: read-only, zero-extended `tval`.
- TICLR: always reads 0.
  - A write with `wmask[0] & wdata[0]` clears `ti`.
  - TICLR writes have no other effect.
- Writes to TVAL and to unmapped addresses are ignored. `hit` is 0 for unmapped addresses and `rdata` is 0.
- Timer counter `tval`, TIMER_W bits, evaluated each cycle with this priority:
  1. TCFG write: update the TCFG fields, then load `tval <= {InitVal_new, 2'b00}`. No expiry is evaluated this cycle.
  2. Else if `En` and `tval != 0`: `tval <= tval - 1`.
  3. Else if `En` and `tval == 0` (expiry):
     - `ti <= 1`.
     - If Periodic: `tval <= {InitVal, 2'b00}`.
     - Otherwise: clear `En`; `tval` holds 0.
  4. Else `tval` holds.
- TI priority: expiry set wins over a same-cycle TICLR clear.
- Periodic with InitVal = 0: expiry every cycle; `ti` stays 1.
- Synchroniser: `hw_s` / `ipi_s` are the outputs of a `SYNC_STAGES`-deep flop chain. No edge detection; lines are level-sensitive.
- `int_signal` and `is_bits` are combinational from registered state and the inputs `sw_int`, `ecfg_lie`, `crmd_ie`.

## Timing
- Reset (asynchronous assert, deassert on the clock) forces:
  - `tid = CORE_ID`; TCFG = 0; `tval = 0`; `ti = 0`; all synchroniser flops 0.
  - Hence `is_bits = {11'b0, sw_int}`, and `int_signal` depends only on `sw_int`.
- Reset mid-count aborts immediately. No expiry fires on the reset release edge.
- Write latency: a write at edge N is visible on `rdata` after edge N.
- TCFG write to expiry: writing En=1 with InitVal=K at edge N gives:
  - `tval = 4K` after N, decrementing one per cycle;
  - `tval = 0` after N+4K;
  - `ti = 1` after N+4K+1.
- Periodic reload happens on that same expiry edge. The period is 4K+1 cycles.
- Synchroniser latency: an input change appears in `is_bits` after `SYNC_STAGES` edges.
- `int_signal` has zero added latency from `ecfg_lie`, `crmd_ie` and `sw_int`.

## Test plan
- Reset, then read all four CSRs:
  - TID = CORE_ID; TCFG = 0; TVAL = 0; TICLR = 0; `ti` = 0.
  - `hit` = 1 for 0x40/0x41/0x42/0x44 and 0 for 0x43.
- One-shot: write TCFG=0x0000_0009 (En, InitVal=2).
  - TVAL reads 8, 7 … 0.
  - `ti` rises 9 cycles after the write edge.
  - TCFG.En reads 0; TVAL holds 0.
- Periodic: write TCFG=0x0000_0007 (En, Periodic, InitVal=1).
  - `ti` rises at cycle 5; TVAL reloads to 4.
  - TICLR write 1 drops `ti`; it re-rises 5 cycles later.
  - A TICLR clear issued in the expiry cycle leaves `ti` = 1.
- Masked writes: TID=0xFFFF_FFFF with `wmask`=0x0000_FF00 → TID reads `CORE_ID & ~32'hFF00 | 32'hFF00`.
  - TCFG write mid-count restarts from the new InitVal with no expiry.
- Interrupts: `hw_int[0]`=1 → `is_bits[2]` after 2 edges.
  - `int_signal` = 1 only with `ecfg_lie[2]` = 1 and `crmd_ie` = 1.
  - Likewise `ipi_int` → bit 12 and timer `ti` → bit 11 under `ecfg_lie[11]`.
- Parameters TIMER_W=12, HW_INT_N=3:
  - TCFG write 0xFFFF_FFFF reads 0x0000_0FFF and TVAL loads 0xFFC.
  - `is_bits[9:5]` stay 0.

Source files
------------

// File: rtl/csr_timer_int.sv
// Timer (TID/TCFG/TVAL/TICLR) and interrupt-pending unit for the LoongArch CSR file.
// Owns the constant timer, the TI latch and the hw/ipi synchronisers feeding ESTAT.IS.
module csr_timer_int #(
    parameter int unsigned TIMER_W     = 32,
    parameter int unsigned HW_INT_N    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] CORE_ID     = 32'h0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [13:0]         csr_num,
    input  logic                we,
    input  logic [31:0]         wdata,
    input  logic [31:0]         wmask,
    output logic [31:0]         rdata,
    output logic                hit,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                ipi_int,
    input  logic [1:0]          sw_int,
    input  logic [12:0]         ecfg_lie,
    input  logic                crmd_ie,
    output logic [12:0]         is_bits,
    output logic                int_signal
);

    localparam logic [13:0] ADDR_TID   = 14'h40;
    localparam logic [13:0] ADDR_TCFG  = 14'h41;
    localparam logic [13:0] ADDR_TVAL  = 14'h42;
    localparam logic [13:0] ADDR_TICLR = 14'h44;

    logic [31:0]         tid_q, tid_d;
    logic [TIMER_W-1:0]  tcfg_q, tcfg_d;
    logic [TIMER_W-1:0]  tval_q, tval_d;
    logic                ti_q, ti_d;
    logic                expire;
    logic                tid_wr, tcfg_wr, ticlr_wr;
    logic [TIMER_W-1:0]  reload;
    logic [TIMER_W-1:0]  mask_t, wdata_t;

    logic [SYNC_STAGES-1:0][HW_INT_N-1:0] hw_sync_q;
    logic [SYNC_STAGES-1:0]               ipi_sync_q;
    logic [7:0]                           hw_pad;

    assign tid_wr   = we && (csr_num == ADDR_TID);
    assign tcfg_wr  = we && (csr_num == ADDR_TCFG);
    assign ticlr_wr = we && (csr_num == ADDR_TICLR);
    assign mask_t   = wmask[TIMER_W-1:0];
    assign wdata_t  = wdata[TIMER_W-1:0];
    assign reload   = {tcfg_q[TIMER_W-1:2], 2'b00};

    always_comb begin
        tid_d  = tid_q;
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_d   = ti_q;
        expire = 1'b0;
        if (tid_wr) begin
            tid_d = (wmask & wdata) | (~wmask & tid_q);
        end
        // A TCFG write reloads the counter and suppresses expiry for this cycle.
        if (tcfg_wr) begin
            tcfg_d = (mask_t & wdata_t) | (~mask_t & tcfg_q);
            tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TIMER_W'(1);
            end else begin
                expire = 1'b1;
                if (tcfg_q[1]) begin
                    tval_d = reload;
                end else begin
                    tcfg_d[0] = 1'b0;
                end
            end
        end
        // Expiry set beats a same-cycle TICLR clear.
        if (expire) begin
            ti_d = 1'b1;
        end else if (ticlr_wr && wmask[0] && wdata[0]) begin
            ti_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q      <= CORE_ID;
            tcfg_q     <= '0;
            tval_q     <= '0;
            ti_q       <= 1'b0;
            hw_sync_q  <= '0;
            ipi_sync_q <= '0;
        end else begin
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            ti_q       <= ti_d;
            hw_sync_q  <= {hw_sync_q[SYNC_STAGES-2:0], hw_int};
            ipi_sync_q <= {ipi_sync_q[SYNC_STAGES-2:0], ipi_int};
        end
    end

    always_comb begin
        hw_pad                = '0;
        hw_pad[HW_INT_N-1:0]  = hw_sync_q[SYNC_STAGES-1];
    end

    assign is_bits    = {ipi_sync_q[SYNC_STAGES-1], ti_q, 1'b0, hw_pad, sw_int};
    assign int_signal = crmd_ie & (|(ecfg_lie & is_bits));

    always_comb begin
        rdata = '0;
        hit   = 1'b0;
        case (csr_num)
            ADDR_TID: begin
                hit   = 1'b1;
                rdata = tid_q;
            end
            ADDR_TCFG: begin
                hit   = 1'b1;
                rdata = 32'(tcfg_q);
            end
            ADDR_TVAL: begin
                hit   = 1'b1;
                rdata = 32'(tval_q);
            end
            ADDR_TICLR: begin
                hit   = 1'b1;
            end
            default: begin
                hit   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_timer_int.sv
// Self-checking bench for csr_timer_int: directed scenarios plus randomized traffic,
// compared every cycle against a timeline-based model of the timer and interrupt path.
module tb_csr_timer_int;

    localparam logic [31:0] CORE_ID = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_num;
    logic        we;
    logic [31:0] wdata, wmask, rdata;
    logic        hit;
    logic [7:0]  hw_int;
    logic        ipi_int;
    logic [1:0]  sw_int;
    logic [12:0] ecfg_lie;
    logic        crmd_ie;
    logic [12:0] is_bits;
    logic        int_signal;

    logic [13:0] s_csr;
    logic        s_we;
    logic [31:0] s_wdata, s_wmask, s_rdata;
    logic        s_hit;
    logic [2:0]  s_hw;
    logic [12:0] s_is;
    logic        s_int;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_timer_int #(.CORE_ID(CORE_ID)) dut (
        .clk(clk), .resetn(resetn), .csr_num(csr_num), .we(we), .wdata(wdata),
        .wmask(wmask), .rdata(rdata), .hit(hit), .hw_int(hw_int), .ipi_int(ipi_int),
        .sw_int(sw_int), .ecfg_lie(ecfg_lie), .crmd_ie(crmd_ie), .is_bits(is_bits),
        .int_signal(int_signal)
    );

    csr_timer_int #(.TIMER_W(12), .HW_INT_N(3)) dut_small (
        .clk(clk), .resetn(resetn), .csr_num(s_csr), .we(s_we), .wdata(s_wdata),
        .wmask(s_wmask), .rdata(s_rdata), .hit(s_hit), .hw_int(s_hw), .ipi_int(1'b0),
        .sw_int(2'b00), .ecfg_lie(13'h0), .crmd_ie(1'b0), .is_bits(s_is),
        .int_signal(s_int)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the timer is described by the edge of its last load and elapsed edges since.
    int unsigned cyc, ld;
    logic [31:0] m_tid;
    logic [29:0] m_k;
    bit          m_per, m_en0, m_ti;
    logic [7:0]  hwq[$];
    bit          ipq[$];

    function automatic logic [31:0] m_four();
        return {m_k, 2'b00};
    endfunction

    function automatic int unsigned m_e();
        return cyc - ld;
    endfunction

    function automatic bit m_en_now();
        if (!m_en0) return 1'b0;
        if (m_per) return 1'b1;
        return m_e() <= m_four();
    endfunction

    function automatic logic [31:0] m_tval();
        if (!m_en0) return m_four();
        if (m_per) return m_four() - (m_e() % (m_four() + 1));
        return (m_e() <= m_four()) ? m_four() - m_e() : 32'h0;
    endfunction

    function automatic logic [31:0] m_tcfg();
        return {m_k, m_per, m_en_now()};
    endfunction

    function automatic bit m_expiry();
        if (!m_en0 || m_e() == 0) return 1'b0;
        if (m_per) return (m_e() % (m_four() + 1)) == 0;
        return m_e() == m_four() + 1;
    endfunction

    task automatic m_reset();
        cyc = 0; ld = 0; m_k = '0; m_per = 0; m_en0 = 0; m_ti = 0;
        m_tid = CORE_ID;
        hwq = '{8'h0, 8'h0};
        ipq = '{1'b0, 1'b0};
    endtask

    task automatic m_update();
        logic [31:0] old_tcfg, nt;
        bit          ex;
        if (!resetn) begin
            m_reset();
            return;
        end
        old_tcfg = m_tcfg();
        cyc++;
        ex = m_expiry();
        if (we && csr_num == 14'h40) m_tid = (wmask & wdata) | (~wmask & m_tid);
        if (we && csr_num == 14'h41) begin
            nt    = (wmask & wdata) | (~wmask & old_tcfg);
            m_k   = nt[31:2];
            m_per = nt[1];
            m_en0 = nt[0];
            ld    = cyc;
            ex    = 1'b0;
        end
        if (ex) m_ti = 1'b1;
        else if (we && csr_num == 14'h44 && wmask[0] && wdata[0]) m_ti = 1'b0;
        hwq.push_back(hw_int);
        void'(hwq.pop_front());
        ipq.push_back(ipi_int);
        void'(ipq.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #2;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_num = a; wdata = d; wmask = m; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic        e_hit;
        logic [12:0] e_is;
        e_hit = (csr_num == 14'h40) || (csr_num == 14'h41) || (csr_num == 14'h42) ||
                (csr_num == 14'h44);
        case (csr_num)
            14'h40:  e_rd = m_tid;
            14'h41:  e_rd = m_tcfg();
            14'h42:  e_rd = m_tval();
            default: e_rd = 32'h0;
        endcase
        e_is = {ipq[0], m_ti, 1'b0, hwq[0], sw_int};
        check("cmp_rdata", rdata, e_rd);
        check("cmp_hit", 32'(hit), 32'(e_hit));
        check("cmp_is_bits", 32'(is_bits), 32'(e_is));
        check("cmp_int_signal", 32'(int_signal), 32'(crmd_ie & (|(ecfg_lie & e_is))));
    end

    initial begin
        resetn = 1'b0; csr_num = 14'h40; we = 1'b0; wdata = '0; wmask = '0;
        hw_int = '0; ipi_int = 1'b0; sw_int = '0; ecfg_lie = '0; crmd_ie = 1'b0;
        s_csr = '0; s_we = 1'b0; s_wdata = '0; s_wmask = '1; s_hw = '0;
        m_reset();
        repeat (3) step();
        resetn = 1'b1;

        // Reset values and address decode.
        csr_num = 14'h40; #1 check("rst_tid", rdata, CORE_ID); step();
        csr_num = 14'h41; #1 check("rst_tcfg", rdata, 32'h0); step();
        csr_num = 14'h42; #1 check("rst_tval", rdata, 32'h0); check("hit_42", 32'(hit), 1); step();
        csr_num = 14'h44; #1 check("rst_ticlr", rdata, 32'h0); check("hit_44", 32'(hit), 1); step();
        csr_num = 14'h43; #1 check("hit_43", 32'(hit), 0); check("rst_ti", 32'(is_bits[11]), 0);
        step();

        // One-shot, InitVal=2.
        wr(14'h41, 32'h9, 32'hFFFF_FFFF);
        csr_num = 14'h42;
        for (int i = 8; i >= 0; i--) begin
            #1 check("os_tval", rdata, 32'(i));
            check("os_ti_low", 32'(is_bits[11]), 0);
            step();
        end
        #1 check("os_ti_high", 32'(is_bits[11]), 1);
        check("os_tval_hold", rdata, 32'h0);
        step();
        csr_num = 14'h41; #1 check("os_en_clear", rdata, 32'h8);

        // Periodic, InitVal=1: period 5.
        wr(14'h44, 32'h1, 32'h1);
        wr(14'h41, 32'h7, 32'hFFFF_FFFF);
        csr_num = 14'h42; #1 check("per_load", rdata, 32'h4);
        repeat (4) step();
        #1 check("per_zero", rdata, 32'h0); check("per_ti_low", 32'(is_bits[11]), 0);
        step();
        #1 check("per_ti_high", 32'(is_bits[11]), 1); check("per_reload", rdata, 32'h4);
        wr(14'h44, 32'h1, 32'h1);
        #1 check("per_clr", 32'(is_bits[11]), 0);
        csr_num = 14'h42;
        repeat (3) step();
        #1 check("per_ti_still_low", 32'(is_bits[11]), 0);
        step();
        #1 check("per_ti_rerise", 32'(is_bits[11]), 1);
        wr(14'h44, 32'h1, 32'h1);
        #1 check("per_clr2", 32'(is_bits[11]), 0);
        repeat (3) step();
        wr(14'h44, 32'h1, 32'h1);
        #1 check("per_clr_vs_expiry", 32'(is_bits[11]), 1);

        // Masked writes and mid-count restart.
        wr(14'h40, 32'hFFFF_FFFF, 32'h0000_FF00);
        csr_num = 14'h40; #1 check("mask_tid", rdata, 32'h0000_FFA5);
        wr(14'h41, 32'h10, 32'hF0);
        csr_num = 14'h41; #1 check("mask_tcfg", rdata, 32'h17);
        csr_num = 14'h42; #1 check("mask_tval", rdata, 32'd20);
        repeat (3) step();
        #1 check("mid_count", rdata, 32'd17);
        wr(14'h41, 32'h9, 32'hFFFF_FFFF);
        csr_num = 14'h42; #1 check("mid_restart", rdata, 32'd8);

        // A TCFG write on the would-be expiry edge suppresses expiry.
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);
        wr(14'h44, 32'h1, 32'h1);
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        #1 check("wr_no_expiry", 32'(is_bits[11]), 0);
        step();
        csr_num = 14'h41;
        #1 check("k0_expiry", 32'(is_bits[11]), 1); check("k0_en_clear", rdata, 32'h0);

        // Periodic InitVal=0 keeps TI set even through a clear.
        wr(14'h41, 32'h3, 32'hFFFF_FFFF);
        step();
        wr(14'h44, 32'h1, 32'h1);
        #1 check("k0_per_ti", 32'(is_bits[11]), 1);
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);
        wr(14'h44, 32'h1, 32'h1);

        // Interrupt paths; also the narrow instance.
        ecfg_lie = 13'h0004; crmd_ie = 1'b1; hw_int = 8'h01;
        s_csr = 14'h41; s_wdata = 32'hFFFF_FFFF; s_we = 1'b1; s_hw = 3'b111;
        step();
        s_we = 1'b0;
        #1 check("hw_sync1", 32'(is_bits[2]), 0);
        check("small_tcfg", s_rdata, 32'h0000_0FFF);
        s_csr = 14'h42;
        #1 check("small_tval", s_rdata, 32'h0000_0FFC);
        step();
        #1 check("hw_sync2", 32'(is_bits[2]), 1); check("hw_int_sig", 32'(int_signal), 1);
        check("small_hw", 32'(s_is[4:2]), 32'h7); check("small_pad", 32'(s_is[9:5]), 32'h0);
        crmd_ie = 1'b0;
        #1 check("hw_ie_off", 32'(int_signal), 0);
        crmd_ie = 1'b1; ecfg_lie = 13'h0;
        #1 check("hw_lie_off", 32'(int_signal), 0);
        hw_int = 8'h00; ipi_int = 1'b1; ecfg_lie = 13'h1000;
        step(); step();
        #1 check("ipi_bit", 32'(is_bits[12]), 1); check("ipi_sig", 32'(int_signal), 1);
        ipi_int = 1'b0; ecfg_lie = 13'h0800;
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        step();
        #1 check("ti_sig", 32'(int_signal), 1);
        wr(14'h44, 32'h1, 32'h1);
        sw_int = 2'b10; ecfg_lie = 13'h0002;
        #1 check("sw_sig", 32'(int_signal), 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                we = 1'b0; resetn = 1'b0; m_reset();
                step();
                resetn = 1'b1;
                continue;
            end
            we = (r < 40);
            case ($urandom_range(0, 6))
                0: csr_num = 14'h40;
                1, 2: csr_num = 14'h41;
                3: csr_num = 14'h42;
                4: csr_num = 14'h43;
                5: csr_num = 14'h44;
                default: csr_num = 14'($urandom);
            endcase
            wdata = (csr_num == 14'h41) ? 32'($urandom_range(0, 31)) : $urandom;
            wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            sw_int = 2'($urandom); ecfg_lie = 13'($urandom); crmd_ie = 1'($urandom);
            if ($urandom_range(0, 9) == 0) hw_int = 8'($urandom);
            if ($urandom_range(0, 9) == 0) ipi_int = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
